moore_pattern_tx: RTL and testbench
===================================

MOORE_PATTERN_TX -- requirements
Module: moore_pattern_tx

Interface
REQ-001 Parameter: PRE_LEN, default 5, number of preamble zero bits; legal range 1..7.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  frame request; sampled only in IDLE.
REQ-005 Port: count  input  4  number of "01" mark pairs in the frame (0..15); latched on start acceptance.
REQ-006 Port: bit_en  input  1  bit-rate enable; a bit period ends on a clock edge where bit_en=1.
REQ-007 Port: abort  input  1  synchronous frame cancel.
REQ-008 Port: sdo  output  1  serial data out; registered; idle level 1.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: mark  output  1  high while sdo carries the 1 bit of a "01" pair, i.e. the bit on which a downstream pattern detector fires.
REQ-011 Port: done  output  1  one-cycle pulse on normal frame completion.
REQ-012 Port: st  output  4  current state code, for HEX display.

Function
REQ-013 The block SHALL generate the frame: PRE_LEN zeros, one sync 1, then count repetitions of "0","1", then return to idle 1.
REQ-014 States and st codes: IDLE=0, PRE=1, SYNC=2, ZERO=3, ONE=4; all other codes are unreachable and SHALL recover to IDLE on the next edge.
REQ-015 The sdo value SHALL be a Moore output of state: IDLE 1, PRE 0, SYNC 1, ZERO 0, ONE 1; mark=1 only in ONE.
REQ-016 IDLE->PRE SHALL occur on the first edge with start=1 and abort=0, independent of bit_en; count is latched into rep_left and pre_cnt is cleared on that edge.
REQ-017 All other transitions SHALL occur only on edges with bit_en=1; with bit_en=0, state, sdo and counters hold.
REQ-018 PRE: pre_cnt increments per bit_en edge; PRE->SYNC on the bit_en edge where pre_cnt=PRE_LEN-1, so PRE lasts exactly PRE_LEN bit periods.
REQ-019 SYNC: on a bit_en edge go to ZERO if rep_left!=0, else to IDLE with done.
REQ-020 ZERO: on a bit_en edge go to ONE.
REQ-021 ONE: on a bit_en edge decrement rep_left; go to ZERO if the pre-decrement rep_left>1, else to IDLE with done.
REQ-022 done SHALL be registered high for exactly the first IDLE cycle after normal completion, and low otherwise.
REQ-023 With bit_en tied high, busy SHALL last exactly PRE_LEN+1+2*count cycles.
REQ-024 start while busy SHALL be ignored; count changes while busy SHALL have no effect.
REQ-025 abort=1 on any edge SHALL force IDLE and sdo=1, and SHALL leave done=0, regardless of bit_en.
REQ-026 abort and start both high in IDLE: abort wins and the frame is not started.
REQ-027 start held high continuously SHALL launch back-to-back frames, with exactly one IDLE cycle (sdo=1, done=1) between them.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, sdo=1, busy=0, mark=0, done=0, st=0, and rep_left=0, pre_cnt=0, without waiting for clk.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no done pulse; after release, the block waits in IDLE for a new start.
REQ-030 After rst deasserts, the first active edge SHALL obey REQ-016 normally.

Verification
REQ-031 bit_en=1, PRE_LEN=5, count=2, one-cycle start -> sdo 0,0,0,0,0,1,0,1,0,1 then 1; mark high on cycles 8 and 10; busy for 10 cycles; done on cycle 11.
REQ-032 count=0 -> sdo 0,0,0,0,0,1 then idle; mark never high; busy for 6 cycles; done once.
REQ-033 bit_en pulsed every 4th cycle, count=1 -> each bit held 4 cycles; bit sequence identical to bit_en=1; st steps 1,2,3,4,0.
REQ-034 abort during the second ZERO of count=3 -> sdo=1 and st=0 on the next edge; no done; a new start is accepted on the following cycle.
REQ-035 rst pulled low asynchronously between edges during PRE -> sdo=1 and busy=0 before the next clk edge; start pulsed during busy with count=9 -> frame continues with the original count.
REQ-036 The bench SHALL loop sdo into the companion Moore pattern detector, run count=15 with bit_en=1, and observe exactly 15 detector output pulses, each one cycle after its mark.

Source files
------------

// File: rtl/moore_pattern_tx.sv
// -----------------------------------------------------------------------------
// moore_pattern_tx
//
// Serial frame generator. On an accepted start it emits PRE_LEN zero bits, one
// sync 1 bit, then `count` repetitions of the pair "0","1", and returns to the
// idle level 1. Bit periods are paced by bit_en; only the IDLE->PRE launch
// ignores bit_en. All data outputs are Moore functions of the state.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous reset, active low
//   start   frame request, sampled only in IDLE
//   count   number of "01" mark pairs (0..15), latched when start is accepted
//   bit_en  bit-rate enable; a bit period ends on an edge with bit_en=1
//   abort   synchronous frame cancel, returns to IDLE without done
//   sdo     registered serial data out, idle level 1
//   busy    high whenever the state is not IDLE
//   mark    high while sdo carries the 1 of a "01" pair
//   done    one-cycle pulse in the first IDLE cycle after normal completion
//   st      current state code (IDLE=0 PRE=1 SYNC=2 ZERO=3 ONE=4)
// -----------------------------------------------------------------------------
module moore_pattern_tx #(
  parameter int PRE_LEN = 5  // preamble zero bits, 1..7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] count,
  input  logic       bit_en,
  input  logic       abort,
  output logic       sdo,
  output logic       busy,
  output logic       mark,
  output logic       done,
  output logic [3:0] st
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    PRE  = 4'd1,
    SYNC = 4'd2,
    ZERO = 4'd3,
    ONE  = 4'd4
  } state_t;

  localparam logic [2:0] PRE_LAST = 3'(PRE_LEN - 1);

  state_t     state, state_nx;
  logic [3:0] rep_left, rep_left_nx;
  logic [2:0] pre_cnt, pre_cnt_nx;
  logic       done_nx;
  logic       sdo_nx;

  // Next-state, counter and registered-output logic.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nx    = state;
    rep_left_nx = rep_left;
    pre_cnt_nx  = pre_cnt;
    done_nx     = 1'b0;

    if (abort) begin
      // Cancel wins over everything, including a start seen in IDLE.
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Launch does not wait for bit_en.
          if (start) begin
            state_nx    = PRE;
            rep_left_nx = count;
            pre_cnt_nx  = 3'd0;
          end
        end
        PRE: begin
          if (bit_en) begin
            if (pre_cnt == PRE_LAST) state_nx = SYNC;
            else                     pre_cnt_nx = pre_cnt + 3'd1;
          end
        end
        SYNC: begin
          if (bit_en) begin
            if (rep_left != 4'd0) begin
              state_nx = ZERO;
            end else begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end
        end
        ZERO: begin
          if (bit_en) state_nx = ONE;
        end
        ONE: begin
          if (bit_en) begin
            rep_left_nx = rep_left - 4'd1;
            // Decision uses the value before the decrement.
            if (rep_left > 4'd1) begin
              state_nx = ZERO;
            end else begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;  // unreachable codes recover to IDLE
      endcase
    end

    // sdo is registered from the next state so it changes together with st.
    case (state_nx)
      PRE, ZERO: sdo_nx = 1'b0;
      default:   sdo_nx = 1'b1;
    endcase
  end

  // NOTE: the reset branch clears every state-holding register, including the
  // counters, so a reset mid-frame leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rep_left <= 4'd0;
      pre_cnt  <= 3'd0;
      sdo      <= 1'b1;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values regardless of statement order.
      state    <= state_nx;
      rep_left <= rep_left_nx;
      pre_cnt  <= pre_cnt_nx;
      sdo      <= sdo_nx;
      done     <= done_nx;
    end
  end

  assign busy = (state != IDLE);
  assign mark = (state == ONE);
  assign st   = state;

endmodule

// File: tb/tb_moore_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_moore_pattern_tx
//
// Scoreboard bench for moore_pattern_tx. Stimulus pushes the expected
// per-cycle output vector {sdo,busy,mark,done,st} for each cycle in which the
// DUT is busy or pulsing done; a negedge monitor pops and compares whenever the
// DUT presents such a cycle. A bench-side Moore "101" detector watches sdo for
// the long frame (the sync bit is the leading 1 of the first hit, so the
// detector fires once per mark).
// -----------------------------------------------------------------------------
module tb_moore_pattern_tx;

  localparam int PRE_LEN = 5;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] count;
  logic       bit_en;
  logic       abort;
  logic       sdo;
  logic       busy;
  logic       mark;
  logic       done;
  logic [3:0] st;

  moore_pattern_tx #(.PRE_LEN(PRE_LEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .count  (count),
    .bit_en (bit_en),
    .abort  (abort),
    .sdo    (sdo),
    .busy   (busy),
    .mark   (mark),
    .done   (done),
    .st     (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       sdo;
    logic       busy;
    logic       mark;
    logic       done;
    logic [3:0] st;
  } obs_t;

  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    phase  = 0;
  string test   = "reset";

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [%s] %s: got 0x%0h expected 0x%0h", test, name, act, exp);
    end
  endtask

  // Push n identical expected cycles.
  function automatic void push(input logic s, input logic b, input logic m,
                               input logic d, input logic [3:0] code, input int n);
    obs_t e;
    e = '{sdo: s, busy: b, mark: m, done: d, st: code};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endfunction

  // Whole frame with each bit held p cycles, ending in the done cycle.
  function automatic void push_frame(input int c, input int p);
    push(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, p * PRE_LEN);
    push(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, p);
    for (int i = 0; i < c; i++) begin
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, p);
      push(1'b1, 1'b1, 1'b1, 1'b0, 4'd4, p);
    end
    push(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1);
  endfunction

  // Cycle edges until the done cycle has been sampled.
  function automatic int frame_edges(input int c, input int p);
    return p * (PRE_LEN + 1 + 2 * c) + 1;
  endfunction

  // Inputs change 1 time unit after posedge; bit_en pulses every p-th cycle
  // counted from the start edge.
  task automatic step(input int n, input int p);
    for (int i = 0; i < n; i++) begin
      phase++;
      bit_en = ((phase % p) == 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input int c, input int p);
    count  = 4'(c);
    start  = 1'b1;
    bit_en = (p == 1);
    phase  = 0;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    obs_t act;
    obs_t exp;
    act = '{sdo: sdo, busy: busy, mark: mark, done: done, st: st};
    if (busy || done) begin
      if (exp_q.size() == 0) begin
        check("output_without_expectation", 0, 1);
      end else begin
        exp = exp_q.pop_front();
        check("frame_cycle", int'(act), int'(exp));
      end
    end
  end

  // Companion Moore "101" detector fed by sdo at bit periods.
  logic [1:0] det_state;
  logic       det_en    = 1'b0;
  logic       prev_mark = 1'b0;
  int         det_pulses = 0;
  wire        det_out = (det_state == 2'd3);

  always @(posedge clk) begin
    if (!det_en) begin
      det_state <= 2'd0;
    end else if (bit_en) begin
      case (det_state)
        2'd0:    det_state <= sdo ? 2'd1 : 2'd0;
        2'd1:    det_state <= sdo ? 2'd1 : 2'd2;
        2'd2:    det_state <= sdo ? 2'd3 : 2'd0;
        default: det_state <= sdo ? 2'd1 : 2'd2;
      endcase
    end
  end

  always @(negedge clk) begin
    if (det_en) begin
      if (det_out) begin
        det_pulses++;
        check("detector_after_mark", int'(prev_mark), 1);
      end
      prev_mark = mark;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; count = 4'd0; bit_en = 1'b0; abort = 1'b0;
    #2 rst = 1'b0;
    #10;
    check("reset_sdo",  int'(sdo),  1);
    check("reset_busy", int'(busy), 0);
    check("reset_mark", int'(mark), 0);
    check("reset_done", int'(done), 0);
    check("reset_st",   int'(st),   0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;

    // Basic frame, count=2, bit_en tied high.
    test = "count2";
    push_frame(2, 1);
    launch(2, 1);
    step(frame_edges(2, 1), 1);

    // Empty frame.
    test = "count0";
    push_frame(0, 1);
    launch(0, 1);
    step(frame_edges(0, 1), 1);

    // Slow bit rate: each bit held 4 cycles, launch edge has bit_en=0.
    test = "bit_en_div4";
    push_frame(1, 4);
    launch(1, 4);
    step(frame_edges(1, 4), 4);

    // abort together with start in IDLE: nothing starts.
    test = "abort_vs_start";
    start = 1'b1; abort = 1'b1;
    step(1, 1);
    start = 1'b0; abort = 1'b0;
    check("abort_start_st",   int'(st),   0);
    check("abort_start_busy", int'(busy), 0);

    // Abort during the second ZERO of a count=3 frame.
    test = "abort_mid";
    push(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, PRE_LEN);
    push(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1);
    push(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1);
    push(1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 1);
    push(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1);
    launch(3, 1);
    step(PRE_LEN + 3, 1);
    check("pre_abort_st", int'(st), 3);
    abort = 1'b1;
    step(1, 1);
    abort = 1'b0;
    check("abort_sdo",  int'(sdo),  1);
    check("abort_st",   int'(st),   0);
    check("abort_done", int'(done), 0);
    test = "restart_after_abort";
    push_frame(0, 1);
    launch(0, 1);
    step(frame_edges(0, 1), 1);

    // start and count changes while busy are ignored.
    test = "start_while_busy";
    push_frame(2, 1);
    launch(2, 1);
    step(3, 1);
    count = 4'd9; start = 1'b1;
    step(1, 1);
    start = 1'b0;
    step(frame_edges(2, 1) - 4, 1);

    // start held high: back-to-back frames with one IDLE/done cycle between.
    test = "back_to_back";
    push_frame(1, 1);
    push_frame(1, 1);
    count = 4'd1; start = 1'b1; bit_en = 1'b1; phase = 0;
    @(posedge clk); #1;
    step(PRE_LEN + 1 + 2 + 1, 1);
    start = 1'b0;
    check("second_frame_st", int'(st), 1);
    step(frame_edges(1, 1) - 1, 1);

    // Asynchronous reset between edges during PRE.
    test = "async_reset";
    push(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 2);
    launch(3, 1);
    step(2, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_sdo",  int'(sdo),  1);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_st",   int'(st),   0);
    check("async_rst_mark", int'(mark), 0);
    @(posedge clk); #4 rst = 1'b1;
    step(3, 1);
    check("post_rst_st",   int'(st),   0);
    check("post_rst_done", int'(done), 0);

    // Long frame through the companion detector.
    test = "detector_count15";
    det_en = 1'b1; prev_mark = 1'b0; det_pulses = 0;
    @(posedge clk); #1;
    push_frame(15, 1);
    launch(15, 1);
    step(frame_edges(15, 1), 1);
    check("detector_pulses", det_pulses, 15);
    det_en = 1'b0;

    test = "end";
    step(2, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
